// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Read-side streaming engine: on a start pulse it walks a block of
// consecutive 32-bit words through the data memory's combinational read
// port and hands them downstream through a small FIFO as a valid/ready
// stream with a per-word last flag.
//
// Optional feature: define MEM_STREAM_STRIDE_EN to add a stride_i port
// (byte stride, latched at start, low two bits ignored). Without it the
// address always advances by one word (4 bytes).

module mem_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef MEM_STREAM_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_transfer_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] strm_data_o,
  output logic                  strm_valid_o,
  output logic                  strm_last_o,
  input  logic                  strm_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   step;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    issued_q, issued_d;
  logic [LEN_WIDTH-1:0]    popped_q, popped_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic                    push;
  logic                    pop;
  logic                    can_accept;
  logic                    push_last;

`ifdef MEM_STREAM_STRIDE_EN
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  assign step = stride_q & WORD_MASK;
`else
  assign step = ADDR_WIDTH'(4);
`endif

  // A word leaves when the head is valid and downstream is ready; a read is
  // issued whenever words remain and the FIFO has (or is freeing) a slot.
  assign pop        = strm_valid_o & strm_ready_i;
  assign can_accept = (count_q < FIFO_FULL) | pop;
  assign push       = (state_q == S_RUN) && (issued_q < len_q) && can_accept;
  assign push_last  = (issued_q + LEN_WIDTH'(1)) == len_q;

  // Next-state and control-register logic for the transfer FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q + LEN_WIDTH'(pop);
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MEM_STREAM_STRIDE_EN
    stride_d = stride_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i & WORD_MASK;
          len_d    = len_i;
          issued_d = '0;
          popped_d = '0;
          busy_d   = 1'b1;
`ifdef MEM_STREAM_STRIDE_EN
          stride_d = stride_i;
`endif
          state_d  = (len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          addr_d   = addr_q + step;
          issued_d = issued_q + LEN_WIDTH'(1);
          if (push_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (popped_d == len_q) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer FSM and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MEM_STREAM_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MEM_STREAM_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  // FIFO pointer and occupancy update; simultaneous push and pop cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO pointers, occupancy and word/last storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      // NOTE: the storage is reset because its head drives strm_data_o, which must read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_data_i;
        fifo_last_q[wr_ptr_q] <= push_last;
      end
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_addr_o     = addr_q;
  assign mem_we_o       = 1'b0;
  assign mem_transfer_o = 4'b0000;
  assign strm_valid_o   = (count_q != '0);
  assign strm_data_o    = fifo_data_q[rd_ptr_q];
  assign strm_last_o    = strm_valid_o & fifo_last_q[rd_ptr_q];

endmodule
